// File: rtl/dror_pkg.sv
// Shared constants, BRAM port payload and loader state encoding for the DROR point pipeline.
package dror_pkg;

    localparam int unsigned N      = 16;
    localparam int unsigned WORD_W = 128;
    localparam int unsigned LANES  = WORD_W / N;
    localparam int unsigned LANE_W = $clog2(LANES);
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned WE_W   = WORD_W / 8;

    localparam logic [ADDR_W-1:0] HDR_ADDR    = 32'd0;
    localparam logic [31:0]       START_FLAG  = 32'd1;
    localparam logic [15:0]       DONE_MARKER = 16'h0fff;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_FLUSH    = 3'd2,
        ST_HDR_SIZE = 3'd3,
        ST_HDR_FLAG = 3'd4,
        ST_WAIT_ACK = 3'd5
    } loader_state_t;

    typedef struct packed {
        logic              en;
        logic [WE_W-1:0]   we;
        logic [ADDR_W-1:0] addr;
        logic [WORD_W-1:0] data;
    } bram_port_t;

    // Data word k lives one word above the header.
    function automatic logic [ADDR_W-1:0] word_addr(input logic [31:0] idx);
        return (idx + 32'd1) << 4;
    endfunction

endpackage

// File: rtl/lane_packer.sv
// Packs N-bit coordinates into one 128-bit word lane by lane; pack_next_c is the word including this cycle's insert.
module lane_packer
    import dror_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    input  logic              insert,
    input  logic [LANE_W-1:0] lane,
    input  logic [N-1:0]      data,
    output logic [WORD_W-1:0] pack_next_c
);

    logic [WORD_W-1:0] pack;

    always_comb begin
        pack_next_c = pack;
        if (insert) begin
            pack_next_c[N*lane +: N] = data;
        end
    end

    // Clear wins over insert: the inserted lane has already gone out with the word write.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            pack <= '0;
        end else begin
            pack <= pack_next_c;
        end
    end

endmodule

// File: rtl/point_cloud_loader.sv
// Streams one point cloud into the x/y/z BRAMs (port B), writes the header last and handshakes with the consumer.
// Optional build macro LOADER_ZERO_DROP_EN: drop all-zero (invalid) returns instead of storing them.
module point_cloud_loader
    import dror_pkg::*;
#(
    parameter int unsigned MAX_POINTS = 8192
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [N-1:0]      s_x,
    input  logic [N-1:0]      s_y,
    input  logic [N-1:0]      s_z,
    input  logic              s_last,
    output logic [ADDR_W-1:0] addr_x,
    output logic [ADDR_W-1:0] addr_y,
    output logic [ADDR_W-1:0] addr_z,
    output logic [WORD_W-1:0] write_in_x,
    output logic [WORD_W-1:0] write_in_y,
    output logic [WORD_W-1:0] write_in_z,
    input  logic [WORD_W-1:0] read_out_y,
    output logic              en_x,
    output logic              en_y,
    output logic              en_z,
    output logic [WE_W-1:0]   we_x,
    output logic [WE_W-1:0]   we_y,
    output logic [WE_W-1:0]   we_z,
    output logic              busy,
    output logic [31:0]       points_loaded,
    output logic              overflow
);

    loader_state_t     state, state_nxt;
    logic [31:0]       count, count_nxt;
    logic [31:0]       word_idx, word_nxt;
    logic [31:0]       loaded_nxt;
    logic              busy_nxt, ovf_nxt;
    logic              ack_armed, ack_nxt;
    bram_port_t        px_q, py_q, pz_q, px_d, py_d, pz_d;
    logic              accept_c, drop_c, store_c, clear_c, word_full_c;
    logic [LANE_W-1:0] lane_c;
    logic [WORD_W-1:0] pack_x_c, pack_y_c, pack_z_c;
    logic              unused_read_c;

    assign unused_read_c = ^read_out_y[WORD_W-1:32];
    assign accept_c      = s_valid && s_ready;
    assign lane_c        = count[LANE_W-1:0];
    assign word_full_c   = store_c && (lane_c == LANE_W'(LANES - 1));

`ifdef LOADER_ZERO_DROP_EN
    assign drop_c = (s_x == '0) && (s_y == '0) && (s_z == '0);
`else
    assign drop_c = 1'b0;
`endif

    lane_packer u_pack_x (.clock(clock), .reset(reset), .clear(clear_c), .insert(store_c),
                          .lane(lane_c), .data(s_x), .pack_next_c(pack_x_c));
    lane_packer u_pack_y (.clock(clock), .reset(reset), .clear(clear_c), .insert(store_c),
                          .lane(lane_c), .data(s_y), .pack_next_c(pack_y_c));
    lane_packer u_pack_z (.clock(clock), .reset(reset), .clear(clear_c), .insert(store_c),
                          .lane(lane_c), .data(s_z), .pack_next_c(pack_z_c));

    // Port values are computed one cycle ahead so each access appears in the cycle it is owed.
    always_comb begin
        state_nxt  = state;
        count_nxt  = count;
        word_nxt   = word_idx;
        loaded_nxt = points_loaded;
        busy_nxt   = busy;
        ovf_nxt    = overflow;
        ack_nxt    = ack_armed;
        store_c    = 1'b0;
        clear_c    = 1'b0;
        px_d       = '0;
        py_d       = '0;
        pz_d       = '0;

        case (state)
            ST_IDLE, ST_LOAD: begin
                if (accept_c) begin
                    if (state == ST_IDLE) begin
                        busy_nxt = 1'b1;
                        ovf_nxt  = 1'b0;
                    end
                    state_nxt = ST_LOAD;
                    if (!drop_c) begin
                        if (count >= MAX_POINTS) begin
                            ovf_nxt = 1'b1;
                        end else begin
                            store_c   = 1'b1;
                            count_nxt = count + 32'd1;
                        end
                    end
                    // A final partial word goes out together with s_last; FLUSH then only spaces the header.
                    if (word_full_c || (s_last && (store_c || lane_c != '0))) begin
                        px_d    = '{en: 1'b1, we: '1, addr: word_addr(word_idx), data: pack_x_c};
                        py_d    = '{en: 1'b1, we: '1, addr: word_addr(word_idx), data: pack_y_c};
                        pz_d    = '{en: 1'b1, we: '1, addr: word_addr(word_idx), data: pack_z_c};
                        clear_c = 1'b1;
                    end
                    if (word_full_c) begin
                        word_nxt = word_idx + 32'd1;
                    end
                    if (s_last) begin
                        clear_c   = 1'b1;
                        state_nxt = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: begin
                px_d      = '{en: 1'b1, we: '1, addr: HDR_ADDR, data: WORD_W'(count)};
                pz_d      = '{en: 1'b1, we: '1, addr: HDR_ADDR, data: '0};
                state_nxt = ST_HDR_SIZE;
            end
            ST_HDR_SIZE: begin
                if (count == 32'd0) begin
                    state_nxt  = ST_IDLE;
                    busy_nxt   = 1'b0;
                    loaded_nxt = 32'd0;
                    word_nxt   = 32'd0;
                end else begin
                    py_d      = '{en: 1'b1, we: '1, addr: HDR_ADDR, data: WORD_W'(START_FLAG)};
                    state_nxt = ST_HDR_FLAG;
                end
            end
            ST_HDR_FLAG: begin
                py_d      = '{en: 1'b1, we: '0, addr: HDR_ADDR, data: '0};
                ack_nxt   = 1'b0;
                state_nxt = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                // First poll result can still reflect the pre-flag contents, so it is skipped.
                if (ack_armed && read_out_y[31:0] == 32'd0) begin
                    state_nxt  = ST_IDLE;
                    busy_nxt   = 1'b0;
                    loaded_nxt = count;
                    count_nxt  = 32'd0;
                    word_nxt   = 32'd0;
                end else begin
                    py_d    = '{en: 1'b1, we: '0, addr: HDR_ADDR, data: '0};
                    ack_nxt = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= ST_IDLE;
            count         <= '0;
            word_idx      <= '0;
            points_loaded <= '0;
            busy          <= 1'b0;
            overflow      <= 1'b0;
            ack_armed     <= 1'b0;
            s_ready       <= 1'b0;
            px_q          <= '0;
            py_q          <= '0;
            pz_q          <= '0;
        end else begin
            state         <= state_nxt;
            count         <= count_nxt;
            word_idx      <= word_nxt;
            points_loaded <= loaded_nxt;
            busy          <= busy_nxt;
            overflow      <= ovf_nxt;
            ack_armed     <= ack_nxt;
            s_ready       <= (state_nxt == ST_IDLE) || (state_nxt == ST_LOAD);
            px_q          <= px_d;
            py_q          <= py_d;
            pz_q          <= pz_d;
        end
    end

    assign addr_x     = px_q.addr;
    assign addr_y     = py_q.addr;
    assign addr_z     = pz_q.addr;
    assign write_in_x = px_q.data;
    assign write_in_y = py_q.data;
    assign write_in_z = pz_q.data;
    assign en_x       = px_q.en;
    assign en_y       = py_q.en;
    assign en_z       = pz_q.en;
    assign we_x       = px_q.we;
    assign we_y       = py_q.we;
    assign we_z       = pz_q.we;

endmodule

// File: tb/tb_point_cloud_loader.sv
// Scoreboard bench for point_cloud_loader: per-axis expected-write queues fed by a list-level cloud model.
module tb_point_cloud_loader;

    localparam int unsigned MAXP = 16;
`ifdef LOADER_ZERO_DROP_EN
    localparam bit ZD = 1'b1;
`else
    localparam bit ZD = 1'b0;
`endif

    logic         clock;
    logic         reset;
    logic         s_valid, s_ready, s_last;
    logic [15:0]  s_x, s_y, s_z;
    logic [31:0]  addr_x, addr_y, addr_z;
    logic [127:0] write_in_x, write_in_y, write_in_z;
    logic [127:0] read_out_y;
    logic         en_x, en_y, en_z;
    logic [15:0]  we_x, we_y, we_z;
    logic         busy, overflow;
    logic [31:0]  points_loaded;

    point_cloud_loader #(.MAX_POINTS(MAXP)) dut (
        .clock(clock), .reset(reset),
        .s_valid(s_valid), .s_ready(s_ready), .s_x(s_x), .s_y(s_y), .s_z(s_z), .s_last(s_last),
        .addr_x(addr_x), .addr_y(addr_y), .addr_z(addr_z),
        .write_in_x(write_in_x), .write_in_y(write_in_y), .write_in_z(write_in_z),
        .read_out_y(read_out_y),
        .en_x(en_x), .en_y(en_y), .en_z(en_z),
        .we_x(we_x), .we_y(we_y), .we_z(we_z),
        .busy(busy), .points_loaded(points_loaded), .overflow(overflow)
    );

    typedef struct {
        logic [31:0]  addr;
        logic [127:0] data;
    } wr_t;

    wr_t         exp_x[$], exp_y[$], exp_z[$];
    logic [15:0] cx[$], cy[$], cz[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          t_last = 0;
    logic [31:0] y_word0 = 32'd0;
    logic        ack_clear = 1'b0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Consumer side of the y BRAM: header word 0 only, read-first, 1-cycle read latency.
    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (ack_clear) y_word0 <= 32'd0;
        else if (en_y && we_y == 16'hffff && addr_y == 32'd0) y_word0 <= write_in_y[31:0];
        if (en_y && addr_y == 32'd0) read_out_y <= {96'd0, y_word0};
    end

    initial read_out_y = '0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out, expected DUT event", name);
    endtask

    task automatic pop_check(input int ax, input logic [31:0] a, input logic [127:0] d, input logic [15:0] we);
        wr_t e;
        bit  have = 1'b0;
        case (ax)
            0: if (exp_x.size() > 0) begin e = exp_x.pop_front(); have = 1'b1; end
            1: if (exp_y.size() > 0) begin e = exp_y.pop_front(); have = 1'b1; end
            default: if (exp_z.size() > 0) begin e = exp_z.pop_front(); have = 1'b1; end
        endcase
        if (!have) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write axis %0d: got addr %0h data %0h, expected no write", ax, a, d);
        end else begin
            check($sformatf("we_axis%0d", ax), 128'(we), 128'(16'hffff));
            check($sformatf("addr_axis%0d", ax), 128'(a), 128'(e.addr));
            check($sformatf("data_axis%0d@%0h", ax, a), d, e.data);
            if (a == 32'd0)
                check($sformatf("hdr_latency_axis%0d", ax), 128'(cyc - t_last), (ax == 1) ? 128'd3 : 128'd2);
        end
    endtask

    // Monitor: every port-B write is matched against the next expected write for that axis.
    always @(negedge clock) begin
        if (!reset) begin
            if (en_x && we_x != 16'h0) pop_check(0, addr_x, write_in_x, we_x);
            if (en_y && we_y != 16'h0) pop_check(1, addr_y, write_in_y, we_y);
            if (en_z && we_z != 16'h0) pop_check(2, addr_z, write_in_z, we_z);
        end
    end

    task automatic send_points(input bit with_last);
        int n;
        for (int i = 0; i < cx.size(); i++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clock);
                s_valid = 1'b0;
            end
            @(negedge clock);
            n = 0;
            while (!s_ready && n < 50) begin
                @(negedge clock);
                n++;
            end
            if (!s_ready) fail_now("s_ready_wait");
            s_valid = 1'b1;
            s_x = cx[i];
            s_y = cy[i];
            s_z = cz[i];
            s_last = with_last && (i == cx.size() - 1);
            if (s_last) t_last = cyc;
            @(posedge clock);
        end
        @(negedge clock);
        s_valid = 1'b0;
        s_last = 1'b0;
    endtask

    // Reference: filter, truncate, chunk into 8-lane words, then header (size, zero, flag).
    task automatic run_cloud(input string name);
        logic [15:0]  sx[$], sy[$], sz[$];
        logic [127:0] dx, dy, dz;
        bit           ovf = 1'b0;
        int           nst, nw, idx, n;
        for (int i = 0; i < cx.size(); i++) begin
            if (ZD && cx[i] == 0 && cy[i] == 0 && cz[i] == 0) continue;
            if (sx.size() < MAXP) begin
                sx.push_back(cx[i]); sy.push_back(cy[i]); sz.push_back(cz[i]);
            end else begin
                ovf = 1'b1;
            end
        end
        nst = sx.size();
        nw = (nst + 7) / 8;
        for (int w = 0; w < nw; w++) begin
            dx = '0; dy = '0; dz = '0;
            for (int l = 0; l < 8; l++) begin
                idx = w * 8 + l;
                if (idx < nst) begin
                    dx[16*l +: 16] = sx[idx];
                    dy[16*l +: 16] = sy[idx];
                    dz[16*l +: 16] = sz[idx];
                end
            end
            exp_x.push_back('{32'((w + 1) * 16), dx});
            exp_y.push_back('{32'((w + 1) * 16), dy});
            exp_z.push_back('{32'((w + 1) * 16), dz});
        end
        exp_x.push_back('{32'd0, 128'(nst)});
        exp_z.push_back('{32'd0, 128'd0});
        if (nst > 0) exp_y.push_back('{32'd0, 128'd1});

        send_points(1'b1);

        if (nst > 0) begin
            n = 0;
            while (y_word0 != 32'd1 && n < 30) begin @(negedge clock); n++; end
            if (y_word0 != 32'd1) fail_now({name, "_flag"});
            repeat ($urandom_range(1, 4)) @(negedge clock);
            check({name, "_s_ready_held"}, 128'(s_ready), 128'd0);
            check({name, "_busy_held"}, 128'(busy), 128'd1);
            ack_clear = 1'b1;
            @(negedge clock);
            ack_clear = 1'b0;
        end
        n = 0;
        while (busy && n < 30) begin @(negedge clock); n++; end
        if (busy) fail_now({name, "_busy_drop"});
        check({name, "_points_loaded"}, 128'(points_loaded), 128'(nst));
        check({name, "_overflow"}, 128'(overflow), 128'(ovf));
        check({name, "_s_ready_after"}, 128'(s_ready), 128'd1);
        check({name, "_no_flag_left"}, 128'(y_word0), 128'd0);
        check({name, "_pending_writes"}, 128'(exp_x.size() + exp_y.size() + exp_z.size()), 128'd0);
    endtask

    task automatic clear_cloud();
        cx.delete(); cy.delete(); cz.delete();
    endtask

    task automatic add_point(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
        cx.push_back(x); cy.push_back(y); cz.push_back(z);
    endtask

    initial begin
        reset = 1'b1;
        s_valid = 1'b0; s_last = 1'b0;
        s_x = '0; s_y = '0; s_z = '0;
        repeat (3) @(negedge clock);
        check("rst_s_ready", 128'(s_ready), 128'd0);
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_points_loaded", 128'(points_loaded), 128'd0);
        check("rst_overflow", 128'(overflow), 128'd0);
        check("rst_en", 128'({en_x, en_y, en_z}), 128'd0);
        check("rst_we", 128'({we_x, we_y, we_z}), 128'd0);
        check("rst_addr", 128'({addr_x, addr_y, addr_z}), 128'd0);
        check("rst_data", write_in_x | write_in_y | write_in_z, 128'd0);
        reset = 1'b0;
        @(negedge clock);
        check("s_ready_after_reset", 128'(s_ready), 128'd1);

        clear_cloud();
        for (int i = 0; i < 8; i++) add_point(16'(i + 1), 16'(i + 2), 16'(i + 3));
        run_cloud("eight");

        clear_cloud();
        for (int i = 0; i < 11; i++) add_point(16'(i + 1), 16'(i + 2), 16'(i + 3));
        run_cloud("eleven");

        clear_cloud();
        for (int i = 0; i < 20; i++) add_point(16'($urandom) | 16'h1, 16'($urandom), 16'($urandom));
        run_cloud("overflow");

        clear_cloud();
        add_point(16'h0011, 16'h0012, 16'h0013);
        add_point(16'h0000, 16'h0000, 16'h0000);
        add_point(16'h0031, 16'h0032, 16'h0033);
        add_point(16'h0000, 16'h0000, 16'h0000);
        add_point(16'h0051, 16'h0052, 16'h0053);
        run_cloud("zeros_mixed");

        clear_cloud();
        add_point(16'h0000, 16'h0000, 16'h0000);
        run_cloud("single_zero");

        clear_cloud();
        for (int i = 0; i < 5; i++) add_point(16'(i + 100), 16'(i + 200), 16'(i + 300));
        send_points(1'b0);
        reset = 1'b1;
        @(negedge clock);
        check("midreset_we", 128'({we_x, we_y, we_z}), 128'd0);
        check("midreset_busy", 128'(busy), 128'd0);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        check("midreset_no_flag", 128'(y_word0), 128'd0);
        clear_cloud();
        for (int i = 0; i < 8; i++) add_point(16'(i + 1), 16'(i + 2), 16'(i + 3));
        run_cloud("after_reset");

        for (int c = 0; c < 4; c++) begin
            clear_cloud();
            for (int i = 0; i < int'($urandom_range(1, 24)); i++) begin
                if ($urandom_range(0, 3) == 0) add_point(16'h0, 16'h0, 16'h0);
                else add_point(16'($urandom), 16'($urandom), 16'($urandom));
            end
            run_cloud($sformatf("random%0d", c));
        end

        repeat (3) @(negedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/point_cloud_loader.md
# point_cloud_loader

Loads one LiDAR point cloud from an incoming point stream into the x/y/z point BRAMs. The BRAM interface stage that runs the DROR controller later reads those BRAMs. The loader packs 16-bit coordinates eight per 128-bit word and writes the header word last. It then raises the start flag and holds off the next cloud until the consumer clears the flag. The loader drives port B of the three true-dual-port BRAMs; the consumer owns port A.

## Interface
- N, 16, coordinate width; lanes per word = 128/N = 8
- MAX_POINTS, 8192, BRAM capacity in points, excluding the header word
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- s_valid  in  1  point valid
- s_ready  out  1  loader accepts a point when s_valid && s_ready
- s_x, s_y, s_z  in  N each  point coordinates
- s_last  in  1  marks the final point of the cloud
- addr_x/addr_y/addr_z  out  32  byte address; header at 0, word k at 16*(k+1)
- write_in_x/_y/_z  out  128  write data
- read_out_y  in  128  y BRAM read data, 1-cycle latency (x/z read data unused)
- en_x/en_y/en_z  out  1  BRAM enable
- we_x/we_y/we_z  out  16  byte write enables
- busy  out  1  high from the first accepted point until the acknowledge
- points_loaded  out  32  point count of the last completed cloud
- overflow  out  1  sticky until reset or next cloud start; cloud exceeded MAX_POINTS

## Operation
- States: IDLE, LOAD, FLUSH, HDR_SIZE, HDR_FLAG, WAIT_ACK.
- IDLE and LOAD: s_ready=1. All other states: s_ready=0.
- Point lane placement: lane = count mod 8, at bits [N*lane +: N] of each axis pack register.
- The 8th lane of a word is accepted at cycle t:
  - full word written at t+1, all three BRAMs, we=16'hffff
  - word index increments
  - pack registers clear
- Accepted s_last at t:
  - FLUSH at t+1 writes the partial word (unused lanes = 0) if it holds at least one point
  - HDR_SIZE at t+2: x word 0 = {96'b0, count}; z word 0 = 0 (clears the consumer's done marker)
  - HDR_FLAG at t+3: y word 0 = {96'b0, 32'd1}
  - WAIT_ACK from t+4
- WAIT_ACK:
  - drives addr_y=0, en_y=1, we_y=0
  - exits to IDLE on the first cycle at least 2 cycles after the flag write where read_out_y[31:0]==0
  - points_loaded is updated and busy drops on that exit
- Overflow: once count==MAX_POINTS, further points are still accepted but not stored or counted, and overflow is set. Header size is clamped to MAX_POINTS.
- Empty cloud (count 0 at s_last, only possible with the configured zero-drop feature): size 0 is written, HDR_FLAG is skipped, and the loader returns to IDLE directly.
- Count arithmetic is 32-bit unsigned. Word address = (word_idx+1)<<4.

## Timing
- Reset values:
  - s_ready=0 during reset, 1 from the first cycle after reset
  - all addr, write_in, en, we = 0
  - busy=0, points_loaded=0, overflow=0; state IDLE; packs and counters 0
- Throughput: 1 point/cycle in LOAD. Word write latency: 1 cycle after the completing point.
- s_last on a point that also completes a word: that word is written at t+1, FLUSH writes nothing, and the header timing is unchanged.
- Reset mid-cloud: returns to IDLE next cycle. No header or flag is written; already-written data words remain in BRAM. The consumer never starts on a partial cloud.
- en_* is 0 in IDLE and in every cycle without an access. x/z port enables stay 0 in WAIT_ACK.

## Configuration
- LOADER_ZERO_DROP_EN:
  - defined: an accepted point with x=y=z=0 (invalid LiDAR return) is consumed but neither stored nor counted. s_last on such a point still ends the cloud.
  - undefined: every accepted point is stored. Zero points collide with the outlier-erase marker downstream; this mode is for bring-up only.

## Structure
- Shared package dror_pkg:
  - WORD_W=128
  - LANES=WORD_W/N
  - HDR_ADDR=0
  - START_FLAG=32'd1
  - DONE_MARKER=16'h0fff
  - loader state enum
- Sub-module lane_packer: N-bit lane shift/insert into a 128-bit register with clear. Instantiated once per axis.

## Test plan
- 8 points with x=i+1, y=i+2, z=i+3, s_last on point 8:
  - addr 16 written at t+1 with lanes 1..8 (y: 2..9, z: 3..10)
  - x hdr = 8 at t+2; y flag = 1 at t+3
  - s_ready low until the bench clears y[31:0]; then points_loaded=8
- 11 points: words at addr 16 and addr 32; word 2 lanes 3..7 = 0; header size 11.
- MAX_POINTS=16, 20 points sent:
  - all 20 handshakes accepted
  - only 16 stored (addr 16, 32)
  - header size 16, overflow=1
- With LOADER_ZERO_DROP_EN, 5 points of which points 2 and 4 are all zero:
  - header size 3; lanes 0..2 hold points 1, 3, 5
- With LOADER_ZERO_DROP_EN, a single zero point with s_last: size 0 written, no flag written, back to IDLE, busy low.
- reset asserted after 5 points:
  - next cycle all we_*=0 and no header written
  - fresh 8-point cloud afterwards loads from addr 16 with size 8
